// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: 4-deep command FIFO feeding an external ALU, sanitized in-order responses
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_sel,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_cin,
  input  logic       cmd_bin,
  output logic [3:0] alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  output logic       alu_bin,
  input  logic [7:0] alu_out1,
  input  logic [7:0] alu_out2,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_out1,
  output logic [7:0] rsp_out2,
  output logic       rsp_cout,
  output logic [3:0] rsp_sel,
  output logic       rsp_err,
  output logic       busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  logic [1:0]  state;
  logic [21:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        run, push, pop, legal, arith, wide;
  logic [21:0] head;
  // run holds cmd_ready low until the first edge after reset release
  assign cmd_ready = run && count < 3'd4;
  assign push = cmd_valid && cmd_ready;
  assign pop = count != 3'd0 && (state == IDLE || (state == RESP && rsp_ready));
  assign busy = state != IDLE || count != 3'd0;
  assign head = mem[rd_ptr];
  assign legal = alu_sel < 4'd6;
  assign arith = alu_sel < 4'd2;
  assign wide = alu_sel == 4'd2 || alu_sel == 4'd5;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_bin};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run <= 1'b0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count <= 3'd0;
      {alu_sel, alu_a, alu_b, alu_cin, alu_bin} <= 22'd0;
      rsp_valid <= 1'b0;
      rsp_out1 <= 8'd0;
      rsp_out2 <= 8'd0;
      rsp_cout <= 1'b0;
      rsp_sel <= 4'd0;
      rsp_err <= 1'b0;
    end else begin
      run <= 1'b1;
      wr_ptr <= push ? wr_ptr + 2'd1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 2'd1 : rd_ptr;
      count <= count + {2'd0, push} - {2'd0, pop};
      if (pop) {alu_sel, alu_a, alu_b, alu_cin, alu_bin} <= head;
      case (state)
        IDLE: state <= pop ? ISSUE : IDLE;
        ISSUE: begin
          rsp_out1 <= legal ? alu_out1 : 8'd0;
          rsp_out2 <= wide ? alu_out2 : 8'd0;
          rsp_cout <= arith ? alu_cout : 1'b0;
          rsp_sel <= alu_sel;
          rsp_err <= !legal;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= pop ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: random + directed stimulus checked every cycle against a queue-based model
module tb_alu_op_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_sel = 4'd0;
  logic [7:0] cmd_a = 8'd0, cmd_b = 8'd0;
  logic       cmd_cin = 1'b0, cmd_bin = 1'b0;
  logic [3:0] alu_sel;
  logic [7:0] alu_a, alu_b, alu_out1, alu_out2;
  logic       alu_cin, alu_bin, alu_cout;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_out1, rsp_out2;
  logic       rsp_cout, rsp_err, busy;
  logic [3:0] rsp_sel;
  int checks = 0, failures = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_bin(cmd_bin),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_bin(alu_bin),
    .alu_out1(alu_out1), .alu_out2(alu_out2), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out1(rsp_out1), .rsp_out2(rsp_out2),
    .rsp_cout(rsp_cout), .rsp_sel(rsp_sel), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in: drives junk on fields the sequencer is expected to mask
  logic [8:0] alu_tmp;
  always_comb begin
    alu_tmp = 9'd0;
    alu_out1 = alu_a | 8'h01;
    alu_out2 = alu_a ^ 8'h5A;
    alu_cout = 1'b1;
    case (alu_sel)
      4'd0: begin alu_tmp = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin}; alu_out1 = alu_tmp[7:0]; alu_cout = alu_tmp[8]; end
      4'd1: begin alu_tmp = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_bin}; alu_out1 = alu_tmp[7:0]; alu_cout = alu_tmp[8]; end
      4'd2: begin alu_out1 = alu_a << 2; alu_out2 = alu_a >> 2; end
      4'd3: alu_out1 = alu_a << 2;
      4'd4: alu_out1 = alu_a >> 2;
      4'd5: begin alu_out1 = ~alu_a; alu_out2 = ~alu_b; end
      default: ;
    endcase
  end

  typedef struct { logic [3:0] sel; logic [7:0] o1, o2; logic c, e; int acc; } rsp_t;
  rsp_t q[$];
  int cyc = 0, last_hs = -100, rel_edges = 0;

  function automatic rsp_t exp_of(int sel, int a, int b, int cin, int bin);
    rsp_t r;
    int s;
    r.sel = 4'(sel); r.o1 = 8'd0; r.o2 = 8'd0; r.c = 1'b0; r.e = 1'b0; r.acc = 0;
    if (sel == 0) begin s = a + b + cin; r.o1 = 8'(s % 256); r.c = s > 255; end
    else if (sel == 1) begin s = a - b - bin; r.o1 = 8'((s + 256) % 256); r.c = s < 0; end
    else if (sel == 2) begin r.o1 = 8'((a * 4) % 256); r.o2 = 8'(a / 4); end
    else if (sel == 3) r.o1 = 8'((a * 4) % 256);
    else if (sel == 4) r.o1 = 8'(a / 4);
    else if (sel == 5) begin r.o1 = 8'(255 - a); r.o2 = 8'(255 - b); end
    else r.e = 1'b1;
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rel_edges <= 0; else rel_edges <= rel_edges + 1;

  // compare process: every negedge, all outputs against the model
  always @(negedge clk) begin
    int t_val, t_iss, fifo_cnt;
    cyc++;
    if (!rst_n) begin
      q.delete();
      last_hs = -100;
      chk("reset_state", {rsp_valid, busy, cmd_ready, rsp_err, rsp_cout, rsp_sel, rsp_out1, rsp_out2}, 0);
      chk("reset_alu", {alu_sel, alu_a, alu_b, alu_cin, alu_bin}, 0);
    end else begin
      t_val = 0; t_iss = 0; fifo_cnt = q.size();
      if (q.size() > 0) begin
        t_val = (q[0].acc + 3 > last_hs + 2) ? q[0].acc + 3 : last_hs + 2;
        t_iss = t_val - 1;
        if (cyc >= t_iss) fifo_cnt--;
      end
      chk("rsp_valid", rsp_valid, q.size() > 0 && cyc >= t_val);
      if (rsp_valid && q.size() > 0)
        chk("rsp_fields", {rsp_sel, rsp_out1, rsp_out2, rsp_cout, rsp_err},
            {q[0].sel, q[0].o1, q[0].o2, q[0].c, q[0].e});
      chk("cmd_ready", cmd_ready, rel_edges > 0 && fifo_cnt < 4);
      chk("busy", busy, q.size() != 0);
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        void'(q.pop_front());
        last_hs = cyc;
      end
      if (cmd_valid && cmd_ready) begin
        rsp_t r;
        r = exp_of(int'(cmd_sel), int'(cmd_a), int'(cmd_b), int'(cmd_cin), int'(cmd_bin));
        r.acc = cyc;
        q.push_back(r);
      end
    end
  end

  task automatic send(int sel, int a, int b, int cin, int bin);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_sel = 4'(sel); cmd_a = 8'(a); cmd_b = 8'(b); cmd_cin = 1'(cin); cmd_bin = 1'(bin);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(string n, logic [7:0] o1, logic [7:0] o2, logic c, logic e, logic [3:0] s);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    if (!ok) chk({n, "_timeout"}, 0, 1);
    else chk(n, {rsp_sel, rsp_out1, rsp_out2, rsp_cout, rsp_err}, {s, o1, o2, c, e});
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rsp_t r;
    r = exp_of(0, 'hF0, 'h20, 1, 0); chk("model_add", {r.o1, r.o2, r.c, r.e}, {8'h11, 8'h00, 1'b1, 1'b0});
    r = exp_of(1, 'h05, 'h07, 0, 0); chk("model_sub", {r.o1, r.o2, r.c, r.e}, {8'hFE, 8'h00, 1'b1, 1'b0});
    r = exp_of(2, 'h81, 'h00, 0, 0); chk("model_shift", {r.o1, r.o2, r.c, r.e}, {8'h04, 8'h20, 1'b0, 1'b0});
    r = exp_of(9, 'hFF, 'h00, 1, 1); chk("model_illegal", {r.o1, r.o2, r.c, r.e}, {8'h00, 8'h00, 1'b0, 1'b1});
    cycles(3);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    cycles(2);
    send(0, 'hF0, 'h20, 1, 0);
    wait_rsp("add", 8'h11, 8'h00, 1'b1, 1'b0, 4'd0);
    cycles(2);
    send(1, 'h05, 'h07, 0, 0);
    send(2, 'h81, 'h00, 0, 0);
    wait_rsp("sub", 8'hFE, 8'h00, 1'b1, 1'b0, 4'd1);
    wait_rsp("shift", 8'h04, 8'h20, 1'b0, 1'b0, 4'd2);
    cycles(3);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i, 16 * i + 3, 7 * i + 1, i & 1, (i >> 1) & 1);
    @(negedge clk);
    chk("full_not_ready", cmd_ready, 1'b0);
    cycles(6);
    rsp_ready = 1'b1;
    cycles(15);
    send(9, 'hFF, 'h00, 1, 1);
    wait_rsp("illegal", 8'h00, 8'h00, 1'b0, 1'b1, 4'd9);
    cycles(3);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i, 'h40 + i, 'h11, 1, 0);
    cycles(4);
    chk("pre_reset_queue", q.size(), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {rsp_valid, busy, cmd_ready}, 3'b000);
    cycles(2);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    cycles(10);
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom % 3) != 0;
      cmd_sel = ($urandom % 4 == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      cmd_cin = 1'($urandom); cmd_bin = 1'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      cycles(1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    begin
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
        @(negedge clk);
        done = q.size() == 0 && !busy;
      end
      chk("drain", done, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
